// File: rtl/bp_me_pkg.sv
// Shared types for the memory-command burst-to-lite converter: processor
// configuration lookup, BedRock memory header layout, FSM state encodings
// and message classification helpers.
package bp_me_pkg;

  typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

  typedef struct packed {
    int paddr_width;
    int cce_block_width;
    int lce_id_width;
    int lce_assoc;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_gp = '{
    paddr_width:     40,
    cce_block_width: 512,
    lce_id_width:    4,
    lce_assoc:       8
  };

  // Only the default configuration is populated in this slice.
  function automatic bp_proc_param_s bp_get_params(bp_params_e cfg);
    bp_proc_param_s p;
    p = bp_default_cfg_gp;
    case (cfg)
      e_bp_default_cfg: p = bp_default_cfg_gp;
      default:          p = bp_default_cfg_gp;
    endcase
    return p;
  endfunction

  localparam int dword_width_gp     = 64;
  localparam int paddr_width_gp     = bp_default_cfg_gp.paddr_width;
  localparam int cce_block_width_gp = bp_default_cfg_gp.cce_block_width;
  localparam int lce_id_width_gp    = bp_default_cfg_gp.lce_id_width;
  localparam int way_id_width_gp    = $clog2(bp_default_cfg_gp.lce_assoc);
  localparam int block_beats_gp     = cce_block_width_gp / dword_width_gp;
  localparam int beat_cnt_width_gp  = (block_beats_gp > 1) ? $clog2(block_beats_gp) : 1;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [way_id_width_gp-1:0] way_id;
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s     payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  localparam int cce_mem_msg_header_width_gp = $bits(bp_bedrock_mem_header_s);
  localparam int mem_cmd_width_gp = cce_block_width_gp + cce_mem_msg_header_width_gp;

  // Converter FSM states
  typedef logic [1:0] bp_me_burst_state_t;
  localparam bp_me_burst_state_t e_ready   = 2'd0;
  localparam bp_me_burst_state_t e_collect = 2'd1;
  localparam bp_me_burst_state_t e_send    = 2'd2;

  // Writes and atomics carry a data payload; everything else is header-only.
  function automatic logic bp_mem_has_data(bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr) || (t == e_bedrock_mem_amo);
  endfunction

  // Index of the final beat for a message size: one beat up to a dword,
  // then size/8 beats, never more than a full block.
  function automatic logic [beat_cnt_width_gp-1:0] bp_mem_last_beat(bp_bedrock_msg_size_e size);
    int beats;
    if (int'(size) <= 3) beats = 1;
    else beats = 1 << (int'(size) - 3);
    if (beats > block_beats_gp) beats = block_beats_gp;
    return beat_cnt_width_gp'(beats - 1);
  endfunction

endpackage

// File: rtl/bp_me_mem_cmd_burst_to_lite_if.sv
// Burst-side (header + data beats) and lite-side (whole message) channels.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where both valid and ready_and are 1; valid never waits on ready, and the
// payload must stay stable while valid is high and ready_and is low.
interface bp_me_mem_cmd_burst_to_lite_if;
  import bp_me_pkg::*;

  bp_bedrock_mem_header_s        mem_cmd_header_i;
  logic                          mem_cmd_header_v_i;
  logic                          mem_cmd_header_ready_and_o;
  logic [dword_width_gp-1:0]     mem_cmd_data_i;
  logic                          mem_cmd_data_v_i;
  logic                          mem_cmd_data_ready_and_o;
  logic [mem_cmd_width_gp-1:0]   mem_cmd_o;
  logic                          mem_cmd_v_o;
  logic                          mem_cmd_ready_and_i;

  modport slave (
    input  mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
           mem_cmd_ready_and_i,
    output mem_cmd_header_ready_and_o, mem_cmd_data_ready_and_o, mem_cmd_o, mem_cmd_v_o
  );

  modport master (
    output mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
           mem_cmd_ready_and_i,
    input  mem_cmd_header_ready_and_o, mem_cmd_data_ready_and_o, mem_cmd_o, mem_cmd_v_o
  );
endinterface

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; a clear with up in the same cycle
// lands on init+1. Wraps naturally at its width.
module bsg_counter_clear_up #(
  parameter int max_val_p  = 7,
  parameter int init_val_p = 0,
  localparam int width_lp  = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  // Count register: reset/clear to init, otherwise advance on up
  always_ff @(posedge clk_i) begin
    if (reset_i) count_o <= width_lp'(init_val_p);
    else if (clear_i) count_o <= width_lp'(init_val_p) + width_lp'(up_i);
    else if (up_i) count_o <= count_o + width_lp'(1);
  end

endmodule

// File: rtl/bp_me_mem_cmd_burst_to_lite.sv
// Collects a BedRock memory command header plus its data beats and emits a
// single lite message {data, header}. Short messages are replicated across
// the whole block so the consumer can pick any dword slot.
module bp_me_mem_cmd_burst_to_lite
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_me_mem_cmd_burst_to_lite_if.slave bus,
  output bp_me_burst_state_t          state_o
);

  localparam bp_proc_param_s proc_cfg_lp = bp_get_params(bp_params_p);
  localparam int cce_block_width_p = proc_cfg_lp.cce_block_width;
  localparam int block_beats_lp    = cce_block_width_p / dword_width_gp;
  localparam int cnt_width_lp      = (block_beats_lp > 1) ? $clog2(block_beats_lp) : 1;

  bp_me_burst_state_t                             state_r, state_n;
  bp_bedrock_mem_header_s                         header_r;
  logic [block_beats_lp-1:0][dword_width_gp-1:0]  data_r;
  logic [block_beats_lp-1:0][dword_width_gp-1:0]  lite_data;
  logic                                           live_r;
  logic [cnt_width_lp-1:0]                        beat_cnt;
  logic [cnt_width_lp-1:0]                        last_beat;
  logic                                           header_hs, data_hs, send_hs;
  logic                                           reset_li;

  assign reset_li  = ~reset_n_i;
  assign last_beat = bp_mem_last_beat(header_r.size);

  // live_r holds readies low for the first cycle after reset is released.
  assign bus.mem_cmd_header_ready_and_o = reset_n_i & live_r & (state_r == e_ready);
  assign bus.mem_cmd_data_ready_and_o   = reset_n_i & live_r & (state_r == e_collect);
  assign bus.mem_cmd_v_o                = reset_n_i & (state_r == e_send);

  assign header_hs = bus.mem_cmd_header_v_i & bus.mem_cmd_header_ready_and_o;
  assign data_hs   = bus.mem_cmd_data_v_i & bus.mem_cmd_data_ready_and_o;
  assign send_hs   = bus.mem_cmd_v_o & bus.mem_cmd_ready_and_i;

  bsg_counter_clear_up #(
    .max_val_p  (block_beats_lp - 1),
    .init_val_p (0)
  ) beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_li),
    .clear_i (header_hs),
    .up_i    (data_hs),
    .count_o (beat_cnt)
  );

  // Next-state: header -> collect/send, last beat -> send, lite accept -> ready
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:   if (header_hs) state_n = bp_mem_has_data(bus.mem_cmd_header_i.msg_type) ? e_collect : e_send;
      e_collect: if (data_hs && (beat_cnt == last_beat)) state_n = e_send;
      e_send:    if (send_hs) state_n = e_ready;
      default:   state_n = e_ready;
    endcase
  end

  // State, header and beat storage
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= e_ready;
      header_r <= '0;
      data_r   <= '0;
      live_r   <= 1'b0;
    end else begin
      live_r  <= 1'b1;
      state_r <= state_n;
      if (header_hs) begin
        header_r <= bus.mem_cmd_header_i;
        if (!bp_mem_has_data(bus.mem_cmd_header_i.msg_type)) data_r <= '0;
      end
      if (data_hs) data_r[beat_cnt] <= bus.mem_cmd_data_i;
    end
  end

  // Beat count is a power of two, so slot j repeats beat (j mod beats).
  always_comb begin
    lite_data = '0;
    for (int j = 0; j < block_beats_lp; j++) begin
      lite_data[j] = data_r[cnt_width_lp'(j) & last_beat];
    end
  end

  assign bus.mem_cmd_o = {lite_data, header_r};
  assign state_o       = state_r;

endmodule

// File: tb/tb_bp_me_mem_cmd_burst_to_lite.sv
// Directed bench for the burst-to-lite converter with a queue scoreboard.
module tb_bp_me_mem_cmd_burst_to_lite;
  import bp_me_pkg::*;

  localparam int W  = mem_cmd_width_gp;
  localparam int BW = cce_block_width_gp;

  logic clk = 1'b0;
  logic reset_n_i;
  bp_me_burst_state_t state_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int lat_q[$];
  int hs_q[$];
  logic [63:0] beat_mem[8];

  bp_me_mem_cmd_burst_to_lite_if bus();

  bp_me_mem_cmd_burst_to_lite #(.bp_params_p(e_bp_default_cfg)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .bus       (bus),
    .state_o   (state_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                   input bp_bedrock_msg_size_e s,
                                                   input logic [paddr_width_gp-1:0] a);
    bp_bedrock_mem_header_s h;
    h = '0;
    h.msg_type = t;
    h.size = s;
    h.addr = a;
    h.payload.lce_id = 4'd3;
    h.payload.way_id = 3'd5;
    return h;
  endfunction

  // Call at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send_header(input bp_bedrock_mem_header_s h, input bit expect_out,
                             input logic [BW-1:0] exp_data, input int exp_lat, output int hs_cyc);
    int n;
    n = 0;
    hs_cyc = -1;
    bus.mem_cmd_header_i = h;
    bus.mem_cmd_header_v_i = 1'b1;
    @(negedge clk);
    while (!bus.mem_cmd_header_ready_and_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_cmd_header_ready_and_o) begin
      checks++;
      failures++;
      $display("FAIL header_accept actual=timeout required=handshake");
    end else begin
      hs_cyc = cyc;
      if (expect_out) begin
        exp_q.push_back({exp_data, h});
        lat_q.push_back(exp_lat);
        hs_q.push_back(hs_cyc);
      end
    end
    @(posedge clk);
    #1;
    bus.mem_cmd_header_v_i = 1'b0;
  endtask

  // Sends beat_mem[0..n-1]; gap inserts one idle cycle after each beat.
  task automatic send_beats(input int n, input bit gap);
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      bus.mem_cmd_data_i = beat_mem[k];
      bus.mem_cmd_data_v_i = 1'b1;
      @(negedge clk);
      while (!bus.mem_cmd_data_ready_and_o && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!bus.mem_cmd_data_ready_and_o) begin
        checks++;
        failures++;
        $display("FAIL data_accept beat=%0d actual=timeout required=handshake", k);
        bus.mem_cmd_data_v_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      bus.mem_cmd_data_v_i = 1'b0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: output stability while stalled, then pop and compare on accept
  logic [W-1:0] held;
  logic [W-1:0] m_exp;
  int m_lat, m_hs, first_cyc;
  bit v_seen = 1'b0;
  always @(negedge clk) begin
    if (!reset_n_i) begin
      v_seen = 1'b0;
    end else if (bus.mem_cmd_v_o) begin
      if (!v_seen) begin
        v_seen = 1'b1;
        held = bus.mem_cmd_o;
        first_cyc = cyc;
      end else begin
        check("hold_stable", bus.mem_cmd_o, held);
      end
      if (bus.mem_cmd_ready_and_i) begin
        v_seen = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual_valid=1 required_valid=0");
        end else begin
          m_exp = exp_q.pop_front();
          m_lat = lat_q.pop_front();
          m_hs  = hs_q.pop_front();
          check("lite_msg", bus.mem_cmd_o, m_exp);
          if (m_lat > 0) check("latency", W'(first_cyc - m_hs), W'(m_lat));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed stimulus
  initial begin
    logic [BW-1:0] d;
    int hs_a, hs_b, rel;

    reset_n_i = 1'b0;
    bus.mem_cmd_header_i = '0;
    bus.mem_cmd_header_v_i = 1'b0;
    bus.mem_cmd_data_i = '0;
    bus.mem_cmd_data_v_i = 1'b0;
    bus.mem_cmd_ready_and_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_v", W'(bus.mem_cmd_v_o), W'(0));
    check("rst_hdr_ready", W'(bus.mem_cmd_header_ready_and_o), W'(0));
    check("rst_data_ready", W'(bus.mem_cmd_data_ready_and_o), W'(0));
    check("rst_state", W'(state_o), W'(e_ready));
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk);
    check("ready_release_cycle", W'(bus.mem_cmd_header_ready_and_o), W'(0));
    @(negedge clk);
    check("ready_after_release", W'(bus.mem_cmd_header_ready_and_o), W'(1));
    // Data offered while idle must be held off
    bus.mem_cmd_data_v_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_data_ready", W'(bus.mem_cmd_data_ready_and_o), W'(0));
      check("idle_state", W'(state_o), W'(e_ready));
    end
    @(posedge clk);
    #1;
    bus.mem_cmd_data_v_i = 1'b0;

    // Scenario 1: 64B write, back-to-back beats k
    d = '0;
    for (int k = 0; k < 8; k++) begin
      beat_mem[k] = 64'(k);
      d[64*k +: 64] = 64'(k);
    end
    send_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000040), 1'b1, d, 9, hs_a);
    send_beats(8, 1'b0);
    idle(3);

    // Scenario 2: 64B read, header only
    send_header(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80000080), 1'b1, '0, 1, hs_a);
    @(negedge clk);
    check("rd_no_data_ready", W'(bus.mem_cmd_data_ready_and_o), W'(0));
    idle(3);

    // Scenario 3: 4B uncached write replicated into every slot
    beat_mem[0] = 64'h00000000DEADBEEF;
    d = {8{64'h00000000DEADBEEF}};
    send_header(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 40'h00001004), 1'b1, d, 2, hs_a);
    send_beats(1, 1'b0);
    idle(2);

    // 16B write: two beats alternate across the block
    beat_mem[0] = 64'hAA;
    beat_mem[1] = 64'hBB;
    d = {4{64'hBB, 64'hAA}};
    send_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_16, 40'h00002010), 1'b1, d, 3, hs_a);
    send_beats(2, 1'b0);
    idle(2);

    // 8B atomic: one beat, data-carrying type
    beat_mem[0] = 64'h0123456789ABCDEF;
    d = {8{64'h0123456789ABCDEF}};
    send_header(mk_hdr(e_bedrock_mem_amo, e_bedrock_msg_size_8, 40'h00003008), 1'b1, d, 2, hs_a);
    send_beats(1, 1'b0);
    idle(2);

    // 128B uncached write: beat count capped at a full block
    for (int k = 0; k < 8; k++) begin
      beat_mem[k] = 64'hC0DE000000000000 | 64'(k);
      d[64*k +: 64] = 64'hC0DE000000000000 | 64'(k);
    end
    send_header(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_128, 40'h00004000), 1'b1, d, 9, hs_a);
    send_beats(8, 1'b0);
    idle(2);

    // Scenario 4: lite side stalled 10 cycles with a second header waiting
    bus.mem_cmd_ready_and_i = 1'b0;
    send_header(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h00000100), 1'b1, '0, 1, hs_a);
    rel = 0;
    hs_b = 0;
    fork
      send_header(mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h00000200), 1'b1, '0, 0, hs_b);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_hdr_ready", W'(bus.mem_cmd_header_ready_and_o), W'(0));
          check("stall_v", W'(bus.mem_cmd_v_o), W'(1));
        end
        @(posedge clk);
        #1;
        bus.mem_cmd_ready_and_i = 1'b1;
        rel = cyc;
      end
    join
    check("second_accept_cycle", W'(hs_b), W'(rel + 1));
    idle(3);

    // Scenario 5: 64B write with data_v toggling
    for (int k = 0; k < 8; k++) begin
      beat_mem[k] = 64'h5A5A5A5A00000000 | 64'(k);
      d[64*k +: 64] = 64'h5A5A5A5A00000000 | 64'(k);
    end
    send_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000100), 1'b1, d, 16, hs_a);
    send_beats(8, 1'b1);
    idle(3);

    // Scenario 6: reset after 3 of 8 beats discards the message
    for (int k = 0; k < 8; k++) beat_mem[k] = 64'h77 + 64'(k);
    send_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000200), 1'b0, '0, 0, hs_a);
    send_beats(3, 1'b0);
    reset_n_i = 1'b0;
    @(negedge clk);
    check("midrst_v", W'(bus.mem_cmd_v_o), W'(0));
    check("midrst_data_ready", W'(bus.mem_cmd_data_ready_and_o), W'(0));
    check("midrst_hdr_ready", W'(bus.mem_cmd_header_ready_and_o), W'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_v", W'(bus.mem_cmd_v_o), W'(0));
    end
    check("post_rst_state", W'(state_o), W'(e_ready));
    @(posedge clk);
    #1;
    beat_mem[0] = 64'hFEEDFACE12345678;
    d = {8{64'hFEEDFACE12345678}};
    send_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h80000300), 1'b1, d, 2, hs_a);
    send_beats(1, 1'b0);
    idle(5);

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
